// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        RUN,
        FIX
    } state_t;

    localparam int          ITERS     = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input op_t op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/cond_neg32.sv
// Conditional two's-complement negate: y = neg ? -x : x.
// Purely combinational, no latency, no flow control.
module cond_neg32 (
    input  logic [31:0] x,
    input  logic        neg,
    output logic [31:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/muldiv32.sv
// Radix-2 multiply / restoring divide owning HI/LO; START..DONE is 34 edges.
// START is ignored while BUSY; defining MULDIV32_ABORT_EN adds the ABORT input.
module muldiv32
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MTHI,
    input  logic             MTLO,
    input  logic [WIDTH-1:0] WDATA,
`ifdef MULDIV32_ABORT_EN
    input  logic             ABORT,
`endif
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV0
);

    localparam int CW = $clog2(ITERS);

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q, bop, hi_acc, lo_acc;
    logic             res_neg, rem_neg, b_zero;
    logic [CW-1:0]    cnt;

    logic             is_div, sa, sb;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] n0_x, n0_y, n1_x, n1_y;
    logic             n0_neg, n1_neg;

    assign is_div = op_is_div(op_q);
    assign sa     = op_is_signed(op_q) & a_q[WIDTH-1];
    assign sb     = op_is_signed(op_q) & b_q[WIDTH-1];

    // hi_acc:lo_acc is the running product (multiplier shifts out of lo_acc)
    // or remainder:quotient (dividend shifts out of lo_acc).
    assign mul_sum   = {1'b0, hi_acc} + {1'b0, (lo_acc[0] ? bop : '0)};
    assign div_shift = {hi_acc, lo_acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, bop};
    assign div_diff  = div_shift[WIDTH-1:0] - bop;

    // The two negators are shared: operand magnitudes in PREP, result sign fix in FIX.
    // A 64-bit product negate is -lo, and ~hi plus the carry that only exists when lo==0.
    always_comb begin
        n0_x   = lo_acc;
        n0_neg = res_neg;
        n1_x   = hi_acc;
        n1_neg = rem_neg;
        if (state == PREP) begin
            n0_x   = a_q;
            n0_neg = sa;
            n1_x   = b_q;
            n1_neg = sb;
        end else if (!is_div) begin
            n1_x   = (res_neg && lo_acc != '0) ? ~hi_acc : hi_acc;
            n1_neg = res_neg && lo_acc == '0;
        end
    end

    cond_neg32 u_neg0 (.x(n0_x), .neg(n0_neg), .y(n0_y));
    cond_neg32 u_neg1 (.x(n1_x), .neg(n1_neg), .y(n1_y));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            bop     <= '0;
            hi_acc  <= '0;
            lo_acc  <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            b_zero  <= 1'b0;
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DIV0    <= 1'b0;
        end else begin
            DONE <= 1'b0;
`ifdef MULDIV32_ABORT_EN
            if (ABORT && state != IDLE) begin
                state <= IDLE;
                BUSY  <= 1'b0;
            end else begin
`else
            begin
`endif
                case (state)
                    IDLE: begin
                        if (START) begin
                            state <= PREP;
                            BUSY  <= 1'b1;
                            op_q  <= op_t'(OP);
                            a_q   <= A;
                            b_q   <= B;
                            DIV0  <= 1'b0;
                        end else begin
                            if (MTHI) HI <= WDATA;
                            if (MTLO) LO <= WDATA;
                        end
                    end
                    PREP: begin
                        lo_acc  <= n0_y;
                        bop     <= n1_y;
                        hi_acc  <= '0;
                        res_neg <= sa ^ sb;
                        rem_neg <= sa;
                        b_zero  <= (b_q == '0);
                        cnt     <= '0;
                        state   <= RUN;
                    end
                    RUN: begin
                        if (is_div) begin
                            hi_acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            lo_acc <= {lo_acc[WIDTH-2:0], div_ge};
                        end else begin
                            hi_acc <= mul_sum[WIDTH:1];
                            lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(ITERS - 1)) state <= FIX;
                    end
                    FIX: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        if (is_div && b_zero) begin
                            LO   <= DIV0_QUOT;
                            HI   <= a_q;
                            DIV0 <= 1'b1;
                        end else begin
                            LO <= n0_y;
                            HI <= n1_y;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/muldiv32.md
Name: muldiv32

Overview:
- Iterative 32-bit multiply/divide unit for MULT, MULTU, DIV and DIVU. It owns the HI/LO architectural registers.
- Sits in the execute stage beside the ALU and shifter. It takes the same rs/rt operands, and its HI/LO outputs feed the MFHI/MFLO writeback mux.
- Uses a radix-2 shift-add multiply and a restoring shift-subtract divide. The controller stalls the CPU while BUSY is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is verified.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  start request; accepted only while idle.
- OP  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with START.
- A  input  32  rs operand (multiplicand or dividend); sampled with START.
- B  input  32  rt operand (multiplier or divisor); sampled with START.
- MTHI  input  1  write WDATA to HI.
- MTLO  input  1  write WDATA to LO.
- WDATA  input  32  data for MTHI/MTLO.
- HI  output  32  HI register.
- LO  output  32  LO register.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when HI/LO have just been updated by an operation.
- DIV0  output  1  sticky flag: the last divide had B==0. Cleared by the next accepted START.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; HI=0, LO=0, BUSY=0, DONE=0, DIV0=0; iteration counter=0.
- States and transitions:
  - IDLE: START=1 goes to PREP.
  - PREP, 1 cycle: computes operand magnitudes for signed ops and latches the result sign and remainder sign. Goes to RUN.
  - RUN, exactly 32 cycles: counter counts 0..31. Each cycle is one shift-add or shift-subtract step. Goes to FIX.
  - FIX, 1 cycle: conditionally negates the product, quotient or remainder. Writes HI/LO. Pulses DONE. Goes to IDLE.
- Latency: START sampled at edge E0. BUSY is high from after E0 until after E34. HI/LO change at E34, and DONE is high in the cycle following E34. Back-to-back: a START in the DONE cycle is accepted.
- Multiply results: {HI,LO} = A*B, as a 64-bit signed (MULT) or unsigned (MULTU) product.
- Divide results: LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
- B==0 on DIV/DIVU:
  - Full latency is kept.
  - LO=32'hFFFF_FFFF, HI=A, DIV0=1.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0. This falls out of the algorithm naturally; no trap is raised.
- START while BUSY: ignored. The operation in flight is unaffected.
- MTHI/MTLO:
  - Write at the next edge only when state is IDLE and START=0.
  - Ignored while BUSY, and ignored in the same cycle as an accepted START (START has priority).
  - MTHI and MTLO asserted together write both registers.
- Reset mid-operation: abandons immediately to the reset values; no DONE is produced.
- OP, A and B are don't-care after the START cycle.

Optional Feature:
- Macro: MULDIV32_ABORT_EN.
- When defined:
  - Adds input port ABORT (1 bit).
  - ABORT=1 while BUSY returns to IDLE at the next edge, with HI/LO/DIV0 unchanged and no DONE.
  - ABORT takes priority over completion in the FIX cycle.
  - ABORT in IDLE has no effect.
- When undefined: no ABORT port exists, and every accepted operation runs to DONE.

Decomposition:
- Package muldiv_pkg holds:
  - enum op_t: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU (2 bits);
  - enum state_t: IDLE, PREP, RUN, FIX;
  - localparam ITERS=32;
  - localparam DIV0_QUOT=32'hFFFF_FFFF.
- One sub-module, cond_neg32 (output = NEG ? -X : X, combinational). It is instantiated for operand magnitude in PREP and for result fix-up in FIX.

Test Plan:
- MULT A=32'hFFFF_FFFD (-3), B=7 -> DONE at cycle 35 after START; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB; BUSY high for 34 cycles.
- MULTU A=B=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIV A=-7, B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; then DIV A=32'h8000_0000, B=-1 -> LO=32'h8000_0000, HI=0.
- DIVU A=100, B=0 -> LO=32'hFFFF_FFFF, HI=100, DIV0=1; next START clears DIV0.
- MTHI WDATA=32'h1234_5678 while BUSY -> HI unchanged; MTLO with START in the same cycle -> LO gets the result, not WDATA; MTLO in IDLE -> LO=WDATA next edge.
- RST_N low at RUN iteration 10 -> HI=LO=0, BUSY=0 immediately; no DONE. With MULDIV32_ABORT_EN defined, ABORT at iteration 5 -> IDLE next edge, HI/LO unchanged.
